// File: rtl/reg_file_mp.sv
// Multi-ported register file with PC alias at the top index, status register and per-register busy bits.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       pc_write,
    input  logic [DATA_W-1:0]          pc_update,
    input  logic                       pc_inc,
    input  logic                       cspr_write,
    input  logic [DATA_W-1:0]          cspr_update,
    output logic [DATA_W-1:0]          pc,
    output logic [DATA_W-1:0]          cspr
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

    // The top entry of regs_q is never written; the PC lives in pc_q instead.
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] pc_q, pc_d, cspr_q, cspr_d;

    logic [ADDR_W-1:0] wa;
    logic              top_wr;
    logic [DATA_W-1:0] top_data;

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        wa       = '0;
        top_wr   = 1'b0;
        top_data = '0;
        // Ascending port order: the highest-numbered enabled port lands last and wins.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                wa = wr_addr[p*ADDR_W +: ADDR_W];
                if (wa == TOP) begin
                    top_wr   = 1'b1;
                    top_data = wr_data[p*DATA_W +: DATA_W];
                end else begin
                    regs_d[wa] = wr_data[p*DATA_W +: DATA_W];
                    busy_d[wa] = 1'b0;
                end
            end
        end
        // A reservation overrides a same-edge clear so the new producer stays tracked.
        if (rsv_en && rsv_addr != TOP)
            busy_d[rsv_addr] = 1'b1;

        if (pc_write)    pc_d = pc_update;
        else if (top_wr) pc_d = top_data;
        else if (pc_inc) pc_d = pc_q + DATA_W'(4);
        else             pc_d = pc_q;

        cspr_d = cspr_write ? cspr_update : cspr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
            pc_q   <= '0;
            cspr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
            busy_q <= busy_d;
            pc_q   <= pc_d;
            cspr_q <= cspr_d;
        end
    end

    logic [ADDR_W-1:0] ra;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (ra == TOP) begin
                rd_data[k*DATA_W +: DATA_W] = pc_q;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
                rd_busy[k]                  = busy_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            // Gated by rst_n so reads stay zero while reset is held.
            for (int p = 0; p < NUM_WR; p++) begin
                if (rst_n && wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra &&
                    !(ra == TOP && pc_write)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
                    rd_busy[k]                  = 1'b0;
                end
            end
`endif
        end
    end

    assign pc   = pc_q;
    assign cspr = cspr_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed cases plus randomized traffic against an array model.
module tb_reg_file_mp;
    localparam int DW = 32, AW = 4, NR = 4, NW = 3, DEPTH = 16, TOPI = 15;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en = '0;
    logic [NW*AW-1:0]  wr_addr = '0;
    logic [NW*DW-1:0]  wr_data = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;
    logic              pc_write = 1'b0, pc_inc = 1'b0, cspr_write = 1'b0;
    logic [DW-1:0]     pc_update = '0, cspr_update = '0;
    logic [DW-1:0]     pc, cspr;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pc_write(pc_write), .pc_update(pc_update), .pc_inc(pc_inc),
        .cspr_write(cspr_write), .cspr_update(cspr_update), .pc(pc), .cspr(cspr));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [DW-1:0] mem [DEPTH];
    bit            mbusy [DEPTH];
    logic [DW-1:0] mpc, mcspr;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; mbusy[i] = 0; end
        mpc = '0; mcspr = '0;
    endtask

    // Apply the architectural effect of the current inputs, as one edge would.
    task automatic model_edge();
        bit top_hit = 0;
        logic [DW-1:0] top_val = '0;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
                int a = int'(wr_addr[p*AW +: AW]);
                if (a == TOPI) begin top_hit = 1; top_val = wr_data[p*DW +: DW]; end
                else begin mem[a] = wr_data[p*DW +: DW]; mbusy[a] = 0; end
            end
        end
        if (rsv_en && int'(rsv_addr) != TOPI) mbusy[rsv_addr] = 1;
        if (pc_write)     mpc = pc_update;
        else if (top_hit) mpc = top_val;
        else if (pc_inc)  mpc = mpc + 32'd4;
        if (cspr_write) mcspr = cspr_update;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; rsv_en = 0; pc_write = 0; pc_inc = 0; cspr_write = 0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < NR; k++) begin
            int a = int'(rd_addr[k*AW +: AW]);
            chk({tag, "_data"}, rd_data[k*DW +: DW], (a == TOPI) ? mpc : mem[a]);
            chk({tag, "_busy"}, {31'd0, rd_busy[k]}, {31'd0, (a == TOPI) ? 1'b0 : 1'(mbusy[a])});
        end
        chk({tag, "_pc"}, pc, mpc);
        chk({tag, "_cspr"}, cspr, mcspr);
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    initial begin
        model_reset();
        #12;
        rd_addr = {4'd15, 4'd5, 4'd1, 4'd0};
        check_reads("reset_state");
        // Inputs during reset must be discarded.
        set_wr(0, 1, 32'hAAAA); rsv_en = 1; rsv_addr = 4'd2; pc_inc = 1;
        @(posedge clk); #1;
        check_reads("reset_discard");
        idle();
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Two ports write R0 and R1 in one cycle.
        set_wr(0, 0, 32'h2); set_wr(1, 1, 32'h2);
        tick(); idle();
        rd_addr = {4'd15, 4'd2, 4'd1, 4'd0}; #1;
        chk("r0_after_write", rd_data[0 +: DW], 32'h2);
        chk("r1_after_write", rd_data[DW +: DW], 32'h2);
        check_reads("dual_write");

        // Same-address collision: highest port wins.
        set_wr(0, 2, 32'h11); set_wr(1, 2, 32'h22); set_wr(2, 2, 32'h33);
        tick(); idle();
        chk("collision_r2", rd_data[2*DW +: DW], 32'h33);

        // Reserve R3, write it two cycles later.
        set_rd(0, 3);
        rsv_en = 1; rsv_addr = 4'd3;
        tick(); idle();
        chk("busy_after_rsv", {31'd0, rd_busy[0]}, 32'd1);
        tick();
        chk("busy_held", {31'd0, rd_busy[0]}, 32'd1);
        set_wr(1, 3, 32'h4);
        tick(); idle();
        chk("busy_after_wr", {31'd0, rd_busy[0]}, 32'd0);
        chk("r3_data", rd_data[0 +: DW], 32'h4);

        // Reserve and write the same register together: data lands, busy stays.
        rsv_en = 1; rsv_addr = 4'd3; set_wr(0, 3, 32'h9);
        tick(); idle();
        chk("rsv_wr_busy", {31'd0, rd_busy[0]}, 32'd1);
        chk("rsv_wr_data", rd_data[0 +: DW], 32'h9);

        // PC wrap and priority.
        pc_write = 1; pc_update = 32'hFFFF_FFFC;
        tick(); idle();
        pc_inc = 1;
        tick(); idle();
        chk("pc_wrap", pc, 32'h0);
        pc_write = 1; pc_update = 32'h100; pc_inc = 1; set_wr(0, 15, 32'h200);
        tick(); idle();
        chk("pc_priority", pc, 32'h100);
        set_wr(2, 15, 32'h300); pc_inc = 1;
        tick(); idle();
        chk("pc_port_write", pc, 32'h300);
        set_rd(1, 15); #1;
        chk("pc_alias_read", rd_data[DW +: DW], 32'h300);
        chk("pc_alias_busy", {31'd0, rd_busy[1]}, 32'd0);
        cspr_write = 1; cspr_update = 32'hC0DE;
        tick(); idle();
        chk("cspr_load", cspr, 32'hC0DE);

        // Same-cycle read of a register being written.
        set_wr(0, 6, 32'h55);
        tick(); idle();
        set_rd(2, 6); set_wr(1, 6, 32'h77); #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", rd_data[2*DW +: DW], 32'h77);
`else
        chk("no_bypass_old", rd_data[2*DW +: DW], 32'h55);
`endif
        tick(); idle();
        chk("r6_after_edge", rd_data[2*DW +: DW], 32'h77);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NW; p++) begin
                wr_en[p] = ($urandom_range(0, 2) == 0);
                wr_addr[p*AW +: AW] = AW'($urandom_range(0, 15));
                wr_data[p*DW +: DW] = $urandom;
            end
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 15));
            pc_write = ($urandom_range(0, 7) == 0);
            pc_update = $urandom;
            pc_inc = ($urandom_range(0, 1) == 1);
            cspr_write = ($urandom_range(0, 3) == 0);
            cspr_update = $urandom;
            tick(); idle();
            for (int k = 0; k < NR; k++) set_rd(k, int'($urandom_range(0, 15)));
            #1;
            check_reads("random");
        end

        // Mid-cycle asynchronous reset with live state.
        set_wr(0, 5, 32'hDEAD); rsv_en = 1; rsv_addr = 4'd5;
        tick(); idle();
        set_rd(0, 5); #1;
        chk("r5_before_rst", rd_data[0 +: DW], 32'hDEAD);
        chk("busy5_before_rst", {31'd0, rd_busy[0]}, 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("r5_in_rst", rd_data[0 +: DW], 32'h0);
        chk("busy5_in_rst", {31'd0, rd_busy[0]}, 32'd0);
        chk("pc_in_rst", pc, 32'h0);
        chk("cspr_in_rst", cspr, 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        set_wr(0, 7, 32'h1234);
        tick(); idle();
        set_rd(0, 7); #1;
        chk("first_edge_after_rst", rd_data[0 +: DW], 32'h1234);
        check_reads("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning register address width; depth is 2**ADDR_W, and the top index is the PC alias.
REQ-003 The block SHALL have parameter NUM_RD, default 4, meaning number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 3, meaning number of write ports.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W, meaning packed read addresses, with port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_W, meaning packed read data.
REQ-009 The block SHALL have port rd_busy, output, NUM_RD, meaning the addressed register has a pending reservation.
REQ-010 The block SHALL have port wr_en, input, NUM_WR, meaning per-port write enables.
REQ-011 The block SHALL have port wr_addr, input, NUM_WR*ADDR_W, meaning packed write addresses.
REQ-012 The block SHALL have port wr_data, input, NUM_WR*DATA_W, meaning packed write data.
REQ-013 The block SHALL have port rsv_en and rsv_addr, input, 1 and ADDR_W, meaning reserve destination register (mark busy).
REQ-014 The block SHALL have port pc_write and pc_update, input, 1 and DATA_W, meaning explicit PC load.
REQ-015 The block SHALL have port pc_inc, input, 1, meaning advance PC by 4.
REQ-016 The block SHALL have port cspr_write and cspr_update, input, 1 and DATA_W, meaning status register load.
REQ-017 The block SHALL have ports pc and cspr, output, DATA_W each, meaning current PC and status registers.

Function
REQ-018 Reads SHALL be combinational from registered state; a read of the top index SHALL return pc.
REQ-019 Writes SHALL take effect on the rising clk edge; the new value SHALL be visible on rd_data after that edge (one-cycle write-to-read latency).
REQ-020 When several write ports target the same address in one cycle, the highest-numbered enabled port SHALL win.
REQ-021 A write port targeting the top index SHALL load PC.
REQ-022 PC next-value priority SHALL be: pc_write, then a write port to the top index, then pc_inc (pc+4, wrapping modulo 2**DATA_W), else hold.
REQ-023 cspr SHALL load cspr_update when cspr_write=1, else hold.
REQ-024 busy[i] SHALL set on the edge where rsv_en=1 with rsv_addr=i.
REQ-025 busy[i] SHALL clear on the edge where any write port writes i without a reservation of i.
REQ-026 Simultaneous reserve and write to the same address SHALL leave busy set while the data is written.
REQ-027 rd_busy[k] SHALL equal busy[rd_addr[k]]; the top index SHALL never report busy.

Reset
REQ-028 While rst_n=0, all registers, pc, cspr and busy bits SHALL be 0 immediately, regardless of clk.
REQ-029 rd_data SHALL read 0 and rd_busy SHALL read 0 during reset.
REQ-030 Writes, reservations and PC updates arriving during reset SHALL be discarded.
REQ-031 After reset deasserts, the first rising edge SHALL operate normally.

Configuration
REQ-032 With macro REGFILE_BYPASS_EN defined, a read whose address matches an enabled write in the same cycle SHALL return that write's data combinationally, honouring REQ-020 priority, and rd_busy SHALL read 0 for that port.
REQ-033 Without REGFILE_BYPASS_EN, reads SHALL return only registered state, per REQ-019.

Verification
REQ-034 Reset, then write 0x2 to R0 on port 0 and 0x2 to R1 on port 1 in one cycle -> next cycle, reads of R0 and R1 return 0x2 and 0x2.
REQ-035 Ports 0, 1 and 2 write 0x11, 0x22 and 0x33 to R2 in one cycle -> R2 reads 0x33.
REQ-036 Reserve R3, then write 0x4 to R3 two cycles later -> rd_busy is 1 for R3 after the reserve edge and 0 after the write edge, and R3 reads 0x4.
REQ-037 pc=0xFFFFFFFC, then pc_inc -> pc=0x0; in another cycle, pc_write=0x100, pc_inc=1 and port 0 writes 0x200 to R15 all together -> pc=0x100.
REQ-038 Assert rst_n=0 mid-cycle after R5=0xDEAD and busy[5]=1 -> pc, cspr, R5 and busy all read 0 before the next edge.
REQ-039 With REGFILE_BYPASS_EN, write 0x77 to R6 while reading R6 -> rd_data is 0x77 in the same cycle; without the macro, the old value is returned until the edge.
